// File: rtl/sr_pulse_seq_pkg.sv
// Shared types and constants for the SR pulse sequencer.
package sr_pulse_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_SET    = 2'b01,
    OP_RESET  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_DEAD  = 2'b10
  } state_e;

endpackage

// File: rtl/sr_pulse_timer.sv
// Load/decrement down-counter; done is high while the count sits at zero.
module sr_pulse_timer
  import sr_pulse_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sr_pulse_sequencer.sv
// Timed, mutually exclusive s/r pulse generator for the gate-level SR flip-flop.
// Optional q_fb/fb_err feedback check is built when SR_PULSE_SEQ_FB_CHECK_EN is defined.
module sr_pulse_sequencer
  import sr_pulse_seq_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int DEAD_W  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SR_PULSE_SEQ_FB_CHECK_EN
  input  logic       q_fb,
  output logic       fb_err,
`endif
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       q_exp
);

  generate
    if (PULSE_W < 1 || PULSE_W > 255 || DEAD_W < 0 || DEAD_W > 255) begin : g_bad_param
      $error("sr_pulse_sequencer: PULSE_W must be 1..255 and DEAD_W 0..255");
    end
  endgenerate

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] DEAD_LD  = (DEAD_W == 0) ? '0 : CNT_W'(DEAD_W - 1);

  state_e           state, state_n;
  op_e              op_q, op_n;
  logic             s_n, r_n, q_exp_n;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= OP_NOP;
      s     <= 1'b0;
      r     <= 1'b0;
      q_exp <= 1'b0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      s     <= s_n;
      r     <= r_n;
      q_exp <= q_exp_n;
    end
  end

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    s_n      = s;
    r_n      = r;
    q_exp_n  = q_exp;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        // NOP is consumed here without leaving IDLE
        if (cmd_valid && cmd_op != OP_NOP) begin
          if (cmd_op == OP_TOGGLE) op_n = q_exp ? OP_RESET : OP_SET;
          else                     op_n = op_e'(cmd_op);
          s_n      = (op_n == OP_SET);
          r_n      = (op_n == OP_RESET);
          state_n  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          s_n     = 1'b0;
          r_n     = 1'b0;
          q_exp_n = (op_q == OP_SET);
          if (DEAD_W == 0) begin
            state_n = ST_IDLE;
          end else begin
            state_n  = ST_DEAD;
            tmr_load = 1'b1;
            tmr_val  = DEAD_LD;
          end
        end
      end
      ST_DEAD: begin
        if (tmr_done) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        s_n     = 1'b0;
        r_n     = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

`ifdef SR_PULSE_SEQ_FB_CHECK_EN
  // Sample q_fb on the edge that returns to IDLE, against the post-update shadow.
  logic fb_chk;
  assign fb_chk = tmr_done && (state == ST_DEAD || (state == ST_PULSE && DEAD_W == 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        fb_err <= 1'b0;
    else if (fb_chk && q_fb != q_exp_n) fb_err <= 1'b1;
  end
`endif

endmodule

// File: doc/sr_pulse_sequencer.md
Name: sr_pulse_sequencer

Overview:
- Upstream command stage for the gate-level SR flip-flop.
- Accepts latch commands (SET / RESET / TOGGLE / NOP) over a valid/ready handshake.
- Drives s and r as timed, mutually exclusive pulses, followed by a dead-time.
- Keeps a shadow copy of the expected latch state, so TOGGLE needs no feedback path.

Parameters:
- PULSE_W, 2: cycles s or r is held high per command; legal 1..255.
- DEAD_W, 1: cycles with s=r=0 after each pulse, before the next command is accepted; legal 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_op  input  2  command: 00 NOP, 01 SET, 10 RESET, 11 TOGGLE
- cmd_ready  output  1  sequencer can accept a command
- s  output  1  set drive to the SR flip-flop
- r  output  1  reset drive to the SR flip-flop
- busy  output  1  pulse or dead-time in progress
- q_exp  output  1  shadow of the expected latch state

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; s=0, r=0, busy=0, q_exp=0, counter=0.
  - cmd_ready=1 once rst_n is released.
  - Reset mid-pulse drops s/r immediately; no completion is recorded.
- States: IDLE, PULSE, DEAD.
- cmd_ready = (state==IDLE); it is decoded from registered state only, with no combinational path from cmd_valid.
- busy = (state != IDLE). s and r are registered outputs.
- Accept: cmd_valid & cmd_ready at rising edge k.
  - NOP: consumed with no pulse; state stays IDLE; q_exp unchanged.
  - SET: s=1 for cycles k+1..k+PULSE_W.
  - RESET: r=1 for cycles k+1..k+PULSE_W.
  - TOGGLE: resolved at edge k using the current q_exp (q_exp=0 gives SET, 1 gives RESET). The resolved op is stored in a register.
  - Redundant SET when q_exp=1, or RESET when q_exp=0, still pulses. The latch is idempotent; no suppression.
- PULSE state: counter loads PULSE_W-1 on entry and decrements each cycle. When counter==0:
  - q_exp updates (1 for SET, 0 for RESET).
  - Go to DEAD, or to IDLE if DEAD_W==0.
- DEAD state: s=r=0; counter loads DEAD_W-1 and decrements to 0, then go to IDLE.
- Timing:
  - Next command is accepted at earliest at edge k+PULSE_W+DEAD_W+1 (cmd_ready high in that cycle).
  - Back-to-back throughput: one command per PULSE_W+DEAD_W+1 cycles.
- Invariant: s & r is never 1 in any cycle, including across reset.
- cmd_op is sampled only at accept; changes while busy are ignored.
- Counter is 8 bits; no wrap is possible within the legal parameter range.
- Elaboration error if PULSE_W==0 or either parameter exceeds 255.

Optional Feature:
- Macro: SR_PULSE_SEQ_FB_CHECK_EN.
- Defined:
  - Adds input q_fb (1 bit, synchronous to clk, from the flip-flop q) and output fb_err (1 bit).
  - In the last cycle before returning to IDLE after a SET/RESET, q_fb is compared with the updated q_exp.
  - A mismatch sets fb_err, which is sticky until rst_n.
  - NOP performs no check.
- Undefined: q_fb and fb_err do not exist; no compare logic is built.

Decomposition:
- Package sr_pulse_seq_pkg:
  - op enum (OP_NOP, OP_SET, OP_RESET, OP_TOGGLE).
  - state enum (ST_IDLE, ST_PULSE, ST_DEAD).
  - CNT_W=8 constant.
- One sub-module, sr_pulse_timer: 8-bit load/decrement down-counter with a `done` output at zero. It is shared by the PULSE and DEAD states.

Test Plan:
- Reset then SET with PULSE_W=2, DEAD_W=1, accept at edge 0 -> s=1 in cycles 1-2, s=r=0 in cycle 3, cmd_ready=1 in cycle 4, q_exp=1.
- TOGGLE x3 from reset -> pulses go r? no: s, r, s; q_exp sequence 1,0,1; s&r never 1 (assertion across the whole run).
- cmd_valid held high with SET, RESET back-to-back -> exactly one accept every 4 cycles; ops not dropped or duplicated.
- DEAD_W=0, PULSE_W=1 -> s high 1 cycle, cmd_ready high the very next cycle; NOP accepted with no s/r activity.
- rst_n asserted during cycle 1 of an r pulse -> r=0 immediately; after release q_exp=0, cmd_ready=1, busy=0.
- With SR_PULSE_SEQ_FB_CHECK_EN, q_fb stuck at 0 on a SET -> fb_err=1 at the end of the pulse/dead sequence and stays 1 until rst_n; q_fb tracking correctly -> fb_err stays 0.
